// File: rtl/shifter_pkg.sv
// shifter_pkg: datapath op codes, command op encodings and controller states for shift_seq_ctrl
package shifter_pkg;
  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_LSL  = 3'b010,
    OP_LSR  = 3'b011,
    OP_ASR  = 3'b100
  } dp_op_e;
  typedef enum logic [1:0] {
    CMD_LSL = 2'b00,
    CMD_LSR = 2'b01,
    CMD_ASR = 2'b10,
    CMD_RSV = 2'b11
  } cmd_op_e;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
  function automatic dp_op_e shift_op(input cmd_op_e c);
    return c == CMD_LSL ? OP_LSL : c == CMD_LSR ? OP_LSR : OP_ASR;
  endfunction
endpackage

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences a multi-step shift onto an external datapath (cmd in, op/shamt/d_in/d_out to datapath, rsp out)
module shift_seq_ctrl
  import shifter_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int AMT_W    = 3,
  parameter int STEP_MAX = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [AMT_W-1:0]  cmd_amt,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [2:0]        op,
  output logic [1:0]        shamt,
  output logic [DATA_W-1:0] d_in,
  input  logic [DATA_W-1:0] d_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);
  localparam logic [AMT_W-1:0] STEP = AMT_W'(STEP_MAX);
  state_e             state, state_nx;
  cmd_op_e            op_q;
  logic [AMT_W-1:0]   rem, step;
  logic [DATA_W-1:0]  data_q;
  assign step = rem > STEP ? STEP : rem;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      op_q   <= CMD_LSL;
      rem    <= '0;
      data_q <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && cmd_valid) begin
        op_q   <= cmd_op_e'(cmd_op);
        rem    <= cmd_amt;
        data_q <= cmd_data;
      end else if (state == SHIFT) begin
        rem <= rem - step;
      end
    end
  end
  always_comb begin
    state_nx  = state;
    state_nx  = state == IDLE  ? (cmd_valid ? LOAD : IDLE)
              : state == LOAD  ? (rem == '0 || op_q == CMD_RSV ? DONE : SHIFT)
              : state == SHIFT ? (rem == step ? DONE : SHIFT)
              : (rsp_ready ? IDLE : DONE);
    op        = state == LOAD ? OP_LOAD : state == SHIFT ? shift_op(op_q) : OP_NOP;
    shamt     = state == SHIFT ? 2'(step) : 2'd0;
    d_in      = state == LOAD ? data_q : '0;
    cmd_ready = state == IDLE;
    rsp_valid = state == DONE;
    rsp_data  = d_out;
    rsp_err   = state == DONE && op_q == CMD_RSV;
  end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed vectors, stall/reset sequences and random commands against a shift-result model
module tb_shift_seq_ctrl;
  logic       clk = 0, reset_n = 0, cmd_valid = 0, rsp_ready = 0;
  logic       cmd_ready, rsp_valid, rsp_err;
  logic [1:0] cmd_op = 0, shamt;
  logic [2:0] cmd_amt = 0, op;
  logic [7:0] cmd_data = 0, d_in, d_out, rsp_data, dp = 0;
  int         n_cmp = 0, n_fail = 0;
  logic [2:0] tr_op[$];
  logic [1:0] tr_sh[$];
  typedef struct {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] data;
    logic [7:0] exp_data;
    logic       exp_err;
    int         exp_lat;
    int         exp_nsh;
    logic [5:0] exp_sh;
  } vec_t;
  vec_t vecs[6];
  always #5 clk = ~clk;
  shift_seq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_amt(cmd_amt), .cmd_data(cmd_data), .op(op), .shamt(shamt),
    .d_in(d_in), .d_out(d_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );
  assign d_out = dp;
  always @(posedge clk)
    case (op)
      3'd1:    dp <= d_in;
      3'd2:    dp <= dp << shamt;
      3'd3:    dp <= dp >> shamt;
      3'd4:    dp <= 8'($signed(dp) >>> shamt);
      default: dp <= dp;
    endcase
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  function automatic logic [7:0] ref_result(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d);
    case (o)
      2'd0:    return d << a;
      2'd1:    return d >> a;
      2'd2:    return 8'($signed(d) >>> a);
      default: return d;
    endcase
  endfunction
  task automatic run_cmd(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d, input int hold,
                         input bit poke, output logic [7:0] rd, output logic re, output int lat);
    tr_op.delete();
    tr_sh.delete();
    cmd_op = o; cmd_amt = a; cmd_data = d; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    cmd_op = 2'($urandom); cmd_amt = 3'($urandom); cmd_data = 8'($urandom);
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tr_op.push_back(op);
      tr_sh.push_back(shamt);
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    rd = rsp_data;
    re = rsp_err;
    if (poke) begin
      cmd_valid = 1;
      cmd_data  = ~d;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_data", rsp_data, rd);
      chk("hold_op", op, 0);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_valid", rsp_valid, 1);
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    chk("post_cmd_ready", cmd_ready, 1);
    chk("post_rsp_valid", rsp_valid, 0);
    if (poke) begin
      cmd_valid = 0;
      chk("post_no_accept_op", op, 0);
    end
  endtask
  task automatic verify(input string tag, input logic [1:0] o, input logic [2:0] a, input logic [7:0] d,
                        input logic [7:0] rd, input logic re, input int lat);
    int rem, n;
    rem = o == 2'd3 ? 0 : int'(a);
    n = 0;
    chk({tag, "_data"}, rd, ref_result(o, a, d));
    chk({tag, "_err"}, re, o == 2'd3);
    chk({tag, "_lat"}, lat, o == 2'd3 ? 1 : 1 + (int'(a) + 2) / 3);
    if (tr_op.size() > 0) begin
      chk({tag, "_load_op"}, tr_op[0], 1);
      chk({tag, "_load_sh"}, tr_sh[0], 0);
    end
    while (rem > 0 && n + 1 < tr_op.size()) begin
      n++;
      chk({tag, "_shift_op"}, tr_op[n], 32'(o) + 2);
      chk({tag, "_shamt"}, tr_sh[n], rem > 3 ? 3 : rem);
      rem -= rem > 3 ? 3 : rem;
    end
    chk({tag, "_trace_len"}, tr_op.size(), n + 1 + rem);
  endtask
  initial begin
    logic [7:0] rd;
    logic       re;
    int         lat;
    vecs[0] = '{2'd0, 3'd5, 8'h81, 8'h20, 1'b0, 3, 2, 6'b001011};
    vecs[1] = '{2'd2, 3'd7, 8'h80, 8'hFF, 1'b0, 4, 3, 6'b011111};
    vecs[2] = '{2'd1, 3'd0, 8'hF0, 8'hF0, 1'b0, 1, 0, 6'b000000};
    vecs[3] = '{2'd3, 3'd4, 8'h5A, 8'h5A, 1'b1, 1, 0, 6'b000000};
    vecs[4] = '{2'd1, 3'd3, 8'hF0, 8'h1E, 1'b0, 2, 1, 6'b000011};
    vecs[5] = '{2'd2, 3'd6, 8'h40, 8'h01, 1'b0, 3, 2, 6'b001111};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_op", op, 0);
    chk("rst_shamt", shamt, 0);
    chk("rst_d_in", d_in, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    reset_n = 1;
    @(posedge clk); #1;
    foreach (vecs[k]) begin
      run_cmd(vecs[k].op, vecs[k].amt, vecs[k].data, 1, 0, rd, re, lat);
      chk("vec_data", rd, vecs[k].exp_data);
      chk("vec_err", re, vecs[k].exp_err);
      chk("vec_lat", lat, vecs[k].exp_lat);
      chk("vec_nshift", tr_op.size() - 1, vecs[k].exp_nsh);
      for (int i = 1; i < tr_sh.size() && i <= 3; i++)
        chk("vec_shamt", tr_sh[i], 32'(vecs[k].exp_sh[2*(i-1) +: 2]));
    end
    run_cmd(2'd1, 3'd2, 8'hC3, 4, 1, rd, re, lat);
    verify("stall", 2'd1, 3'd2, 8'hC3, rd, re, lat);
    cmd_op = 2'd0; cmd_amt = 3'd7; cmd_data = 8'hFF; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    @(posedge clk); #1;
    chk("mid_shift_op", op, 2);
    reset_n = 0;
    @(posedge clk); #1;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_op", op, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_err", rsp_err, 0);
    chk("abort_d_in", d_in, 0);
    reset_n = 1;
    @(posedge clk); #1;
    chk("abort_idle_valid", rsp_valid, 0);
    run_cmd(2'd0, 3'd5, 8'h81, 0, 0, rd, re, lat);
    verify("after_rst", 2'd0, 3'd5, 8'h81, rd, re, lat);
    for (int r = 0; r < 40; r++) begin
      logic [1:0] o;
      logic [2:0] a;
      logic [7:0] d;
      o = 2'($urandom);
      a = 3'($urandom);
      d = 8'($urandom);
      run_cmd(o, a, d, $urandom_range(0, 2), 0, rd, re, lat);
      verify("rand", o, a, d, rd, re, lat);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
